// File: rtl/usb_bus_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | usb_bus_scheduler_if : FT600-style bus pins plus TX/RX data-FIFO ports     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface usb_bus_scheduler_if;
  // USB-side handshake
  logic        txe_n_in;
  logic        rxf_n_in;
  logic        wr_n_out;
  logic        rd_n_out;
  logic        oe_n_out;

  // Pin data path (tri-state control lives outside)
  logic [31:0] data_in;
  logic [3:0]  be_in;
  logic [31:0] data_out;
  logic [3:0]  be_out;
  logic        data_oe_out;

  // TX source FIFO (show-ahead)
  logic        tx_fifo_empty_in;
  logic [31:0] tx_fifo_data_in;
  logic        tx_fifo_rd_out;

  // RX sink FIFO
  logic        rx_fifo_full_in;
  logic        rx_fifo_wr_out;
  logic [31:0] rx_fifo_data_out;
  logic [3:0]  rx_fifo_be_out;

  // Status
  logic        busy_out;
  logic        dir_out;

  modport master (
    input  txe_n_in, rxf_n_in, data_in, be_in,
    input  tx_fifo_empty_in, tx_fifo_data_in, rx_fifo_full_in,
    output wr_n_out, rd_n_out, oe_n_out, data_out, be_out, data_oe_out,
    output tx_fifo_rd_out, rx_fifo_wr_out, rx_fifo_data_out, rx_fifo_be_out,
    output busy_out, dir_out
  );

  modport slave (
    output txe_n_in, rxf_n_in, data_in, be_in,
    output tx_fifo_empty_in, tx_fifo_data_in, rx_fifo_full_in,
    input  wr_n_out, rd_n_out, oe_n_out, data_out, be_out, data_oe_out,
    input  tx_fifo_rd_out, rx_fifo_wr_out, rx_fifo_data_out, rx_fifo_be_out,
    input  busy_out, dir_out
  );
endinterface

`default_nettype wire

// File: rtl/usb_bus_scheduler.sv
// +----------------------------------------------------------------------------+
// | usb_bus_scheduler : arbitrates the FT600 bus between TX and RX bursts      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module usb_bus_scheduler #(
  parameter int MAX_BURST  = 256,
  parameter int TURNAROUND = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  usb_bus_scheduler_if.master bus
);

  localparam int CNT_W  = $clog2(MAX_BURST + 1);
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [CNT_W-1:0]  c_last_beat = CNT_W'(MAX_BURST - 1);
  localparam logic [TURN_W-1:0] c_last_turn = TURN_W'(TURNAROUND - 1);
  localparam logic              c_dir_tx    = 1'b0;
  localparam logic              c_dir_rx    = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OE    = 3'd1,
    RX_BURST = 3'd2,
    TX_BURST = 3'd3,
    TURN     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic [TURN_W-1:0]   r_turn_cnt;
  logic                r_last_dir;

  logic                w_rx_req;
  logic                w_tx_req;
  logic                w_grant;
  logic                w_grant_dir;
  logic                w_beat;

  assign w_rx_req = !bus.rxf_n_in && !bus.rx_fifo_full_in;
  assign w_tx_req = !bus.txe_n_in && !bus.tx_fifo_empty_in;

  // Data paths are pure feed-throughs; only the enables depend on state.
  assign bus.data_out         = bus.tx_fifo_data_in;
  assign bus.be_out           = 4'hf;
  assign bus.rx_fifo_data_out = bus.data_in;
  assign bus.rx_fifo_be_out   = bus.be_in;
  assign bus.busy_out         = (r_state != IDLE);
  assign bus.dir_out          = r_last_dir;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state       = r_state;
    w_grant            = 1'b0;
    w_grant_dir        = r_last_dir;
    w_beat             = 1'b0;
    bus.wr_n_out       = 1'b1;
    bus.rd_n_out       = 1'b1;
    bus.oe_n_out       = 1'b1;
    bus.data_oe_out    = 1'b0;
    bus.tx_fifo_rd_out = 1'b0;
    bus.rx_fifo_wr_out = 1'b0;

    case (r_state)
      IDLE: begin
        // On a tie, the direction not served last wins.
        if (w_rx_req && w_tx_req) begin
          w_grant     = 1'b1;
          w_grant_dir = !r_last_dir;
        end else if (w_rx_req) begin
          w_grant     = 1'b1;
          w_grant_dir = c_dir_rx;
        end else if (w_tx_req) begin
          w_grant     = 1'b1;
          w_grant_dir = c_dir_tx;
        end
        if (w_grant) begin
          w_next_state = (w_grant_dir == c_dir_rx) ? RX_OE : TX_BURST;
        end
      end

      RX_OE: begin
        bus.oe_n_out = 1'b0;
        w_next_state = RX_BURST;
      end

      RX_BURST: begin
        bus.oe_n_out       = 1'b0;
        w_beat             = w_rx_req;
        bus.rd_n_out       = !w_beat;
        bus.rx_fifo_wr_out = w_beat;
        if (!w_beat || (r_burst_cnt == c_last_beat)) begin
          w_next_state = TURN;
        end
      end

      TX_BURST: begin
        bus.data_oe_out    = 1'b1;
        w_beat             = w_tx_req;
        bus.wr_n_out       = !w_beat;
        bus.tx_fifo_rd_out = w_beat;
        if (!w_beat || (r_burst_cnt == c_last_beat)) begin
          w_next_state = TURN;
        end
      end

      TURN: begin
        if (r_turn_cnt == c_last_turn) begin
          w_next_state = IDLE;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_burst_cnt <= '0;
      r_turn_cnt  <= '0;
      r_last_dir  <= c_dir_tx;
    end else begin
      if (w_grant) begin
        r_last_dir  <= w_grant_dir;
        r_burst_cnt <= '0;
      end else if (w_beat) begin
        r_burst_cnt <= r_burst_cnt + 1'b1;
      end
      r_turn_cnt <= (r_state == TURN) ? r_turn_cnt + 1'b1 : '0;
    end
  end

endmodule

`default_nettype wire
